// File: rtl/pdm_pkg.sv
// Shared constants and elaboration helpers for the PDM capture front end.
// Holds the CIC width rule, the PDM bit-to-level mapping and the parameter legality checks.
package pdm_pkg;

    localparam int PDM_LEVEL_ONE  = 1;
    localparam int PDM_LEVEL_ZERO = -1;

    // Bit growth of an order-N CIC with ratio R is N*log2(R); two extra bits cover the sign and +/-R^N.
    function automatic int cic_width(input int decim, input int order);
        return order * $clog2(decim) + 2;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int clk_div, input int decim,
                                        input int order, input int tdata_width);
        return (clk_div >= 4) && (clk_div % 2 == 0) &&
               (decim >= 2) && is_pow2(decim) &&
               (order >= 1) && (order <= 6) &&
               (tdata_width >= cic_width(decim, order));
    endfunction

endpackage

// File: rtl/pdm_cic_decimator_if.sv
// AXI4-Stream sample channel carrying signed PCM out of the decimator.
interface pdm_cic_decimator_if #(
    parameter int TDATA_WIDTH = 32
) ();

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/pdm_clkgen.sv
// Microphone clock divider, pdm_data synchronizer and per-period sample strobe.
module pdm_clkgen #(
    parameter int CLK_DIV = 40
) (
    input  logic aclk,
    input  logic resetn,
    input  logic enable,
    input  logic pdm_data,
    output logic pdm_clk,
    output logic strobe,
    output logic pdm_bit
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             sync_meta;
    logic             sync_bit;

    assign div_next = (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;

    // pdm_clk is derived from the next count so the registered clock lines up with div_cnt.
    always_ff @(posedge aclk) begin
        if (!resetn || !enable) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
        end else begin
            div_cnt <= div_next;
            pdm_clk <= (div_next >= DIV_W'(CLK_DIV / 2));
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            sync_meta <= 1'b0;
            sync_bit  <= 1'b0;
        end else begin
            sync_meta <= pdm_data;
            sync_bit  <= sync_meta;
        end
    end

    assign strobe  = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign pdm_bit = sync_bit;

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: clock generation, CIC decimation and a one-beat AXI4-Stream output.
// Integrators run at the PDM rate; combs run once per decimation event, one cycle after it.
module pdm_cic_decimator
    import pdm_pkg::*;
#(
    parameter int CLK_DIV     = 40,
    parameter int DECIM       = 64,
    parameter int CIC_ORDER   = 4,
    parameter int TDATA_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        resetn,
    input  logic                        enable,
    output logic                        pdm_clk,
    input  logic                        pdm_data,
    pdm_cic_decimator_if.master         m_axis,
    output logic                        overflow
);

    localparam int CIC_W  = cic_width(DECIM, CIC_ORDER);
    localparam int DEC_W  = $clog2(DECIM);
    localparam int WARM_W = $clog2(CIC_ORDER + 1);

    if (!params_legal(CLK_DIV, DECIM, CIC_ORDER, TDATA_WIDTH)) begin : g_illegal
        $error("pdm_cic_decimator: illegal CLK_DIV/DECIM/CIC_ORDER/TDATA_WIDTH combination");
    end

    logic                    strobe;
    logic                    pdm_bit;
    logic signed [CIC_W-1:0] x_val;
    logic [DEC_W-1:0]        dec_cnt;
    logic [WARM_W-1:0]       warm_cnt;
    logic                    comb_go;
    logic                    enable_q;
    logic                    emit;
    logic signed [CIC_W-1:0] integ_sum [CIC_ORDER+1];
    logic signed [CIC_W-1:0] comb_diff [CIC_ORDER+1];
    logic signed [CIC_W-1:0] integ_out;
    logic signed [CIC_W-1:0] comb_out;

    pdm_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .aclk     (aclk),
        .resetn   (resetn),
        .enable   (enable),
        .pdm_data (pdm_data),
        .pdm_clk  (pdm_clk),
        .strobe   (strobe),
        .pdm_bit  (pdm_bit)
    );

    assign x_val = pdm_bit ? CIC_W'(PDM_LEVEL_ONE) : CIC_W'(PDM_LEVEL_ZERO);

    // Each integrator adds the freshly updated value of the stage before it.
    assign integ_sum[0] = x_val;
    for (genvar k = 0; k < CIC_ORDER; k++) begin : g_integ
        logic signed [CIC_W-1:0] acc;

        assign integ_sum[k+1] = acc + integ_sum[k];

        always_ff @(posedge aclk) begin
            if (!resetn || !enable) begin
                acc <= '0;
            end else if (strobe) begin
                acc <= integ_sum[k+1];
            end
        end

        if (k == CIC_ORDER - 1) begin : g_last
            assign integ_out = acc;
        end
    end

    assign comb_diff[0] = integ_out;
    for (genvar k = 0; k < CIC_ORDER; k++) begin : g_comb
        logic signed [CIC_W-1:0] dly;

        assign comb_diff[k+1] = comb_diff[k] - dly;

        always_ff @(posedge aclk) begin
            if (!resetn || !enable) begin
                dly <= '0;
            end else if (comb_go) begin
                dly <= comb_diff[k];
            end
        end
    end

    assign comb_out = comb_diff[CIC_ORDER];

    // The first CIC_ORDER combs only flush start-up transients, so they are computed but never emitted.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            dec_cnt  <= '0;
            warm_cnt <= '0;
            comb_go  <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            enable_q <= enable;
            if (!enable) begin
                dec_cnt  <= '0;
                warm_cnt <= '0;
                comb_go  <= 1'b0;
            end else begin
                comb_go <= strobe && (dec_cnt == DEC_W'(DECIM - 1));
                if (strobe) begin
                    dec_cnt <= dec_cnt + 1'b1;
                end
                if (comb_go && (warm_cnt != WARM_W'(CIC_ORDER))) begin
                    warm_cnt <= warm_cnt + 1'b1;
                end
            end
        end
    end

    assign emit = enable && comb_go && (warm_cnt == WARM_W'(CIC_ORDER));

    // A new sample may overwrite a beat only in the cycle that beat is accepted; otherwise it is lost.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            overflow      <= 1'b0;
        end else begin
            if (emit && (!m_axis.tvalid || m_axis.tready)) begin
                m_axis.tvalid <= 1'b1;
                m_axis.tdata  <= TDATA_WIDTH'(comb_out);
            end else if (m_axis.tvalid && m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end

            if (enable && !enable_q) begin
                overflow <= 1'b0;
            end else if (emit && m_axis.tvalid && !m_axis.tready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator at default parameters with hand-derived beat timing and values.
module tb_pdm_cic_decimator;

    localparam int          FIRST_BEAT = 12801;
    localparam int          BEAT_GAP   = 2560;
    localparam logic [31:0] DC_POS     = 32'h0100_0000;
    localparam logic [31:0] DC_NEG     = 32'hFF00_0000;
    localparam logic [31:0] DC_ZERO    = 32'h0000_0000;

    logic aclk;
    logic resetn;
    logic enable;
    logic pdm_clk;
    logic pdm_data;
    logic overflow;

    int   checks      = 0;
    int   passed      = 0;
    int   cycle_count = 0;
    int   t_enable    = 0;
    int   t_beat      = 0;
    logic alt_done    = 1'b0;

    pdm_cic_decimator_if #(.TDATA_WIDTH(32)) axis_if ();

    pdm_cic_decimator #(
        .CLK_DIV     (40),
        .DECIM       (64),
        .CIC_ORDER   (4),
        .TDATA_WIDTH (32)
    ) dut (
        .aclk     (aclk),
        .resetn   (resetn),
        .enable   (enable),
        .pdm_clk  (pdm_clk),
        .pdm_data (pdm_data),
        .m_axis   (axis_if),
        .overflow (overflow)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cycle_count <= cycle_count + 1;

    task automatic wait_for_beat(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge aclk);
            if (axis_if.tvalid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn         = 1'b0;
        enable         = 1'b0;
        pdm_data       = 1'b0;
        axis_if.tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++; if (axis_if.tvalid !== 1'b0) $display("[TB] FAIL reset_tvalid: got %0b expected 0", axis_if.tvalid); else passed++;
        checks++; if (axis_if.tdata !== 32'h0) $display("[TB] FAIL reset_tdata: got %h expected 00000000", axis_if.tdata); else passed++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); else passed++;
        checks++; if (pdm_clk !== 1'b0) $display("[TB] FAIL reset_pdm_clk: got %0b expected 0", pdm_clk); else passed++;
        resetn = 1'b1;
    endtask

    task automatic test_pdm_clk();
        int high_seen;
        int low_run;
        int high_run;
        pdm_data  = 1'b1;
        high_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (pdm_clk !== 1'b0) high_seen++;
        end
        checks++; if (high_seen != 0) $display("[TB] FAIL pdm_clk_disabled: got %0d high cycles expected 0", high_seen); else passed++;

        @(posedge aclk);
        #1 enable = 1'b1;
        t_enable = cycle_count;
        low_run  = 0;
        high_run = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (pdm_clk === 1'b0) low_run++;
            else break;
        end
        if (pdm_clk === 1'b1) high_run = 1;
        for (int i = 0; i < 100 && high_run > 0; i++) begin
            @(negedge aclk);
            if (pdm_clk === 1'b1) high_run++;
            else break;
        end
        checks++; if (low_run != 20) $display("[TB] FAIL pdm_clk_low_phase: got %0d cycles expected 20", low_run); else passed++;
        checks++; if (high_run != 20) $display("[TB] FAIL pdm_clk_high_phase: got %0d cycles expected 20", high_run); else passed++;
    endtask

    task automatic test_const_one();
        bit seen;
        int t_prev;
        wait_for_beat(FIRST_BEAT + 100, seen);
        checks++; if (!seen || (cycle_count - t_enable) != FIRST_BEAT) $display("[TB] FAIL one_first_beat_cycle: got %0d (seen=%0b) expected %0d", cycle_count - t_enable, seen, FIRST_BEAT); else passed++;
        checks++; if (axis_if.tdata !== DC_POS) $display("[TB] FAIL one_first_beat_data: got %h expected %h", axis_if.tdata, DC_POS); else passed++;
        for (int b = 0; b < 2; b++) begin
            t_prev = cycle_count;
            wait_for_beat(BEAT_GAP + 100, seen);
            checks++; if (!seen || (cycle_count - t_prev) != BEAT_GAP) $display("[TB] FAIL one_beat_spacing: got %0d (seen=%0b) expected %0d", cycle_count - t_prev, seen, BEAT_GAP); else passed++;
            checks++; if (axis_if.tdata !== DC_POS) $display("[TB] FAIL one_beat_data: got %h expected %h", axis_if.tdata, DC_POS); else passed++;
        end
        t_beat = cycle_count;
    endtask

    task automatic test_backpressure();
        bit seen;
        int t_first;
        @(posedge aclk);
        #1 axis_if.tready = 1'b0;
        wait_for_beat(BEAT_GAP + 100, seen);
        t_first = cycle_count;
        checks++; if (!seen || (t_first - t_beat) != BEAT_GAP) $display("[TB] FAIL bp_first_beat: got %0d (seen=%0b) expected %0d", t_first - t_beat, seen, BEAT_GAP); else passed++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL bp_overflow_early: got %0b expected 0", overflow); else passed++;

        repeat (BEAT_GAP + 10) @(negedge aclk);
        checks++; if (axis_if.tvalid !== 1'b1) $display("[TB] FAIL bp_tvalid_held: got %0b expected 1", axis_if.tvalid); else passed++;
        checks++; if (axis_if.tdata !== DC_POS) $display("[TB] FAIL bp_tdata_held: got %h expected %h", axis_if.tdata, DC_POS); else passed++;
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL bp_overflow_set: got %0b expected 1", overflow); else passed++;

        axis_if.tready = 1'b1;
        @(negedge aclk);
        checks++; if (axis_if.tvalid !== 1'b0) $display("[TB] FAIL bp_accept_drop: got %0b expected 0", axis_if.tvalid); else passed++;

        wait_for_beat(2 * BEAT_GAP + 100, seen);
        checks++; if (!seen || (cycle_count - t_first) != 2 * BEAT_GAP) $display("[TB] FAIL bp_next_event_beat: got %0d (seen=%0b) expected %0d", cycle_count - t_first, seen, 2 * BEAT_GAP); else passed++;
        checks++; if (axis_if.tdata !== DC_POS) $display("[TB] FAIL bp_next_data: got %h expected %h", axis_if.tdata, DC_POS); else passed++;
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL bp_overflow_sticky: got %0b expected 1", overflow); else passed++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        int t_reset;
        @(posedge aclk);
        #1 axis_if.tready = 1'b0;
        wait_for_beat(BEAT_GAP + 100, seen);
        checks++; if (!seen) $display("[TB] FAIL rst_pending_beat: got tvalid %0b expected 1", axis_if.tvalid); else passed++;

        resetn = 1'b0;
        @(negedge aclk);
        checks++; if (axis_if.tvalid !== 1'b0) $display("[TB] FAIL rst_mid_tvalid: got %0b expected 0", axis_if.tvalid); else passed++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL rst_mid_overflow: got %0b expected 0", overflow); else passed++;
        checks++; if (axis_if.tdata !== 32'h0) $display("[TB] FAIL rst_mid_tdata: got %h expected 00000000", axis_if.tdata); else passed++;
        resetn         = 1'b1;
        axis_if.tready = 1'b1;
        t_reset        = cycle_count;

        wait_for_beat(FIRST_BEAT + 100, seen);
        checks++; if (!seen || (cycle_count - t_reset) != FIRST_BEAT) $display("[TB] FAIL rst_warmup_beat: got %0d (seen=%0b) expected %0d", cycle_count - t_reset, seen, FIRST_BEAT); else passed++;
        checks++; if (axis_if.tdata !== DC_POS) $display("[TB] FAIL rst_warmup_data: got %h expected %h", axis_if.tdata, DC_POS); else passed++;
    endtask

    task automatic test_enable_stop();
        bit seen;
        int high_seen;
        @(posedge aclk);
        #1 axis_if.tready = 1'b0;
        wait_for_beat(BEAT_GAP + 100, seen);
        repeat (BEAT_GAP + 10) @(negedge aclk);
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL stop_overflow_set: got %0b expected 1", overflow); else passed++;

        enable    = 1'b0;
        pdm_data  = 1'b0;
        high_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge aclk);
            if (pdm_clk !== 1'b0) high_seen++;
        end
        checks++; if (high_seen != 0) $display("[TB] FAIL stop_pdm_clk_low: got %0d high cycles expected 0", high_seen); else passed++;
        checks++; if (axis_if.tvalid !== 1'b1) $display("[TB] FAIL stop_beat_kept: got %0b expected 1", axis_if.tvalid); else passed++;
        checks++; if (axis_if.tdata !== DC_POS) $display("[TB] FAIL stop_beat_data: got %h expected %h", axis_if.tdata, DC_POS); else passed++;
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL stop_overflow_kept: got %0b expected 1", overflow); else passed++;

        axis_if.tready = 1'b1;
        @(negedge aclk);
        checks++; if (axis_if.tvalid !== 1'b0) $display("[TB] FAIL stop_accept: got %0b expected 0", axis_if.tvalid); else passed++;

        @(posedge aclk);
        #1 enable = 1'b1;
        t_enable = cycle_count;
        repeat (2) @(negedge aclk);
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL rise_clears_overflow: got %0b expected 0", overflow); else passed++;
    endtask

    task automatic test_const_zero();
        bit seen;
        int t_prev;
        wait_for_beat(FIRST_BEAT + 100, seen);
        checks++; if (!seen || (cycle_count - t_enable) != FIRST_BEAT) $display("[TB] FAIL zero_first_beat_cycle: got %0d (seen=%0b) expected %0d", cycle_count - t_enable, seen, FIRST_BEAT); else passed++;
        checks++; if (axis_if.tdata !== DC_NEG) $display("[TB] FAIL zero_first_data: got %h expected %h", axis_if.tdata, DC_NEG); else passed++;
        t_prev = cycle_count;
        wait_for_beat(BEAT_GAP + 100, seen);
        checks++; if (!seen || (cycle_count - t_prev) != BEAT_GAP) $display("[TB] FAIL zero_spacing: got %0d (seen=%0b) expected %0d", cycle_count - t_prev, seen, BEAT_GAP); else passed++;
        checks++; if (axis_if.tdata !== DC_NEG) $display("[TB] FAIL zero_second_data: got %h expected %h", axis_if.tdata, DC_NEG); else passed++;
    endtask

    task automatic test_alternating();
        bit seen;
        int t_prev;
        @(posedge aclk);
        #1 enable = 1'b0;
        pdm_data = 1'b1;
        repeat (5) @(negedge aclk);
        @(posedge aclk);
        #1 enable = 1'b1;
        t_enable = cycle_count;
        fork
            begin
                while (!alt_done) begin
                    @(posedge pdm_clk);
                    #1 if (!alt_done) pdm_data = ~pdm_data;
                end
            end
        join_none
        wait_for_beat(FIRST_BEAT + 100, seen);
        checks++; if (!seen || (cycle_count - t_enable) != FIRST_BEAT) $display("[TB] FAIL alt_first_beat_cycle: got %0d (seen=%0b) expected %0d", cycle_count - t_enable, seen, FIRST_BEAT); else passed++;
        checks++; if (axis_if.tdata !== DC_ZERO) $display("[TB] FAIL alt_first_data: got %h expected %h", axis_if.tdata, DC_ZERO); else passed++;
        t_prev = cycle_count;
        wait_for_beat(BEAT_GAP + 100, seen);
        checks++; if (!seen || (cycle_count - t_prev) != BEAT_GAP) $display("[TB] FAIL alt_spacing: got %0d (seen=%0b) expected %0d", cycle_count - t_prev, seen, BEAT_GAP); else passed++;
        checks++; if (axis_if.tdata !== DC_ZERO) $display("[TB] FAIL alt_second_data: got %h expected %h", axis_if.tdata, DC_ZERO); else passed++;
        alt_done = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pdm_clk();
        test_const_one();
        test_backpressure();
        test_reset_mid();
        test_enable_stop();
        test_const_zero();
        test_alternating();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
